// File: rtl/minimig_bank_request_queue.sv
// Request queue between the Amiga bank mapper and the SDRAM controller.
// Flattens {one-hot bank, block offset} into a word address and buffers requests in a small FIFO.
module minimig_bank_request_queue #(
  parameter int OFS_W = 18,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         bank,
  input  logic [OFS_W-1:0]   ofs,
  input  logic               wr,
  input  logic [1:0]         be,
  input  logic [15:0]        wdata,
  output logic               sd_valid,
  input  logic               sd_ready,
  output logic [OFS_W+2:0]   sd_addr,
  output logic               sd_wr,
  output logic [1:0]         sd_be,
  output logic [15:0]        sd_wdata,
  output logic               unmapped,
  output logic               conflict,
  output logic [7:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = OFS_W + 3 + 1 + 2 + 16;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds its payload stable until then, and ready never depends on valid.

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [2:0]       bank_index;
  logic             multi;
  logic             no_bank;
  logic             push;
  logic             push_map;
  logic             pop;

  // Highest set bit wins when the mapper selects several blocks at once.
  always_comb begin
    bank_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bank[i]) bank_index = i[2:0];
    end
  end

  assign multi    = |(bank & (bank - 8'd1));
  assign no_bank  = (bank == 8'h00);
  assign in_ready = (count != CNT_W'(DEPTH));
  assign sd_valid = (count != '0);
  assign push     = in_valid && in_ready;
  assign push_map = push && !no_bank;
  assign pop      = sd_valid && sd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      unmapped <= 1'b0;
      conflict <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      count <= count + CNT_W'(push_map) - CNT_W'(pop);
      if (push_map) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      unmapped <= push && no_bank;
      if (push && multi) conflict <= 1'b1;
      if (push && no_bank && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_map) mem[wr_ptr] <= {bank_index, ofs, wr, be, wdata};
  end

  assign head = mem[rd_ptr];
  assign {sd_addr, sd_wr, sd_be, sd_wdata} = sd_valid ? head : '0;

endmodule

// File: tb/tb_minimig_bank_request_queue.sv
// Bench for minimig_bank_request_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_minimig_bank_request_queue;

  localparam int DEPTH = 2;
  localparam int OFS_W = 18;
  localparam int ENT_W = OFS_W + 3 + 1 + 2 + 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         bank = '0;
  logic [OFS_W-1:0]   ofs = '0;
  logic               wr = 1'b0;
  logic [1:0]         be = '0;
  logic [15:0]        wdata = '0;
  logic               sd_valid;
  logic               sd_ready = 1'b0;
  logic [OFS_W+2:0]   sd_addr;
  logic               sd_wr;
  logic [1:0]         sd_be;
  logic [15:0]        sd_wdata;
  logic               unmapped;
  logic               conflict;
  logic [7:0]         drop_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  minimig_bank_request_queue #(.OFS_W(OFS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .bank(bank), .ofs(ofs), .wr(wr), .be(be), .wdata(wdata),
    .sd_valid(sd_valid), .sd_ready(sd_ready), .sd_addr(sd_addr), .sd_wr(sd_wr),
    .sd_be(sd_be), .sd_wdata(sd_wdata), .unmapped(unmapped), .conflict(conflict),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [ENT_W-1:0] exp_q[$];
  bit m_unmapped = 1'b0;
  bit m_conflict = 1'b0;
  int m_drop = 0;
  bit m_acc;
  bit m_pop;

  function automatic logic [2:0] top_bit(input logic [7:0] b);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (b[i]) r = 3'(i);
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_unmapped = 1'b0;
      m_conflict = 1'b0;
      m_drop = 0;
    end else begin
      m_acc = in_valid && (exp_q.size() < DEPTH);
      m_pop = (exp_q.size() > 0) && sd_ready;
      if (m_pop) void'(exp_q.pop_front());
      m_unmapped = m_acc && (bank == 8'h00);
      if (m_acc && (bank == 8'h00) && (m_drop < 255)) m_drop++;
      if (m_acc && ($countones(bank) > 1)) m_conflict = 1'b1;
      if (m_acc && (bank != 8'h00)) exp_q.push_back({top_bit(bank), ofs, wr, be, wdata});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      check("sd_valid", 64'(sd_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        check("head", 64'({sd_addr, sd_wr, sd_be, sd_wdata}), 64'(exp_q[0]));
      check("unmapped", 64'(unmapped), 64'(m_unmapped));
      check("conflict", 64'(conflict), 64'(m_conflict));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [OFS_W-1:0] o, input logic w,
                      input logic [1:0] e, input logic [15:0] d);
    logic acc = 1'b0;
    int n = 0;
    bank = b; ofs = o; wr = w; be = e; wdata = d; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      cycle();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc_last;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sd_valid", 64'(sd_valid), 64'd0);
    check("rst_sd_addr", 64'(sd_addr), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_conflict", 64'(conflict), 64'd0);
    cycle();

    // single mapped write
    sd_ready = 1'b1;
    send(8'h04, 18'h12345, 1'b1, 2'b11, 16'hBEEF);
    @(negedge clk);
    check("single_valid", 64'(sd_valid), 64'd1);
    check("single_addr", 64'(sd_addr), 64'h092345);
    check("single_wr", 64'(sd_wr), 64'd1);
    check("single_be", 64'(sd_be), 64'd3);
    check("single_wdata", 64'(sd_wdata), 64'hBEEF);
    cycle();
    @(negedge clk);
    check("single_popped", 64'(sd_valid), 64'd0);
    cycle();

    // back-pressure fill
    sd_ready = 1'b0;
    send(8'h01, 18'd1, 1'b0, 2'b01, 16'h0001);
    send(8'h01, 18'd2, 1'b0, 2'b10, 16'h0002);
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    cycle();
    bank = 8'h01; ofs = 18'd3; wr = 1'b0; be = 2'b11; wdata = 16'h0003; in_valid = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    check("bp_held_ready", 64'(in_ready), 64'd0);
    check("bp_head1", 64'(sd_addr), 64'd1);
    cycle();
    sd_ready = 1'b1;
    cycle();
    @(negedge clk);
    check("bp_recover_ready", 64'(in_ready), 64'd1);
    check("bp_head2", 64'(sd_addr), 64'd2);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_head3", 64'(sd_addr), 64'd3);
    repeat (2) cycle();

    // unmapped and drop_cnt saturation
    send(8'h00, 18'h00AA, 1'b0, 2'b11, 16'h0);
    @(negedge clk);
    check("unm_pulse", 64'(unmapped), 64'd1);
    check("unm_drop1", 64'(drop_cnt), 64'd1);
    check("unm_no_valid", 64'(sd_valid), 64'd0);
    cycle();
    @(negedge clk);
    check("unm_pulse_end", 64'(unmapped), 64'd0);
    cycle();
    bank = 8'h00; in_valid = 1'b1;
    repeat (300) begin
      ofs = 18'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("unm_saturate", 64'(drop_cnt), 64'hFF);
    cycle();

    // conflict
    sd_ready = 1'b0;
    send(8'h81, 18'd0, 1'b0, 2'b11, 16'h1234);
    @(negedge clk);
    check("conf_addr", 64'(sd_addr), 64'h1C0000);
    check("conf_flag", 64'(conflict), 64'd1);
    cycle();
    sd_ready = 1'b1;
    send(8'h02, 18'd5, 1'b1, 2'b01, 16'h5555);
    repeat (3) cycle();
    @(negedge clk);
    check("conf_sticky", 64'(conflict), 64'd1);
    cycle();

    // streaming
    sd_ready = 1'b1; in_valid = 1'b1; bank = 8'h08; wr = 1'b1; be = 2'b11;
    for (int i = 0; i < 16; i++) begin
      ofs = 18'(18'h100 + i);
      wdata = 16'(i * 3);
      @(negedge clk);
      check("stream_ready", 64'(in_ready), 64'd1);
      if (i > 0) check("stream_out", 64'(sd_addr), 64'(21'h0C0100 + 21'(i - 1)));
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();

    // reset mid-operation with a full queue
    sd_ready = 1'b0;
    send(8'h00, 18'd9, 1'b0, 2'b11, 16'h0);
    send(8'h10, 18'd7, 1'b1, 2'b11, 16'hAAAA);
    send(8'h20, 18'd8, 1'b0, 2'b10, 16'hBBBB);
    @(negedge clk);
    check("mid_full", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_sd_valid", 64'(sd_valid), 64'd0);
    check("mid_conflict", 64'(conflict), 64'd0);
    check("mid_unmapped", 64'(unmapped), 64'd0);
    check("mid_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    sd_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(sd_valid), 64'd0);
    repeat (4) cycle();

    // random traffic
    acc_last = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (!in_valid || acc_last) begin
        in_valid = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0:       bank = 8'h00;
          1:       bank = 8'($urandom_range(1, 255));
          default: bank = 8'(1 << $urandom_range(0, 7));
        endcase
        ofs = 18'($urandom);
        wr = 1'($urandom);
        be = 2'($urandom);
        wdata = 16'($urandom);
      end
      sd_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_last = in_valid && in_ready;
      cycle();
    end
    in_valid = 1'b0;
    sd_ready = 1'b1;
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
